// File: rtl/uart_wbm_pkg.sv
// Shared types and constants for the UART-to-Wishbone debug bridge.
package uart_wbm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WDATA,
    ST_BUS,
    ST_RESP
  } state_t;

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] RSP_OK    = 8'h4B;
  localparam logic [7:0] RSP_ERR   = 8'h45;

  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
  } wb_req_t;

endpackage

// File: rtl/uart_wbm_serdes.sv
// UART byte receiver (2-FF synchroniser, mid-bit sampling) and back-to-back capable transmitter.
module uart_wbm_serdes #(
  parameter int DIV = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic       tx,
  output logic       rx_valid,
  output logic       rx_ferr,
  output logic [7:0] rx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic [7:0] tx_data
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] BIT_END = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF    = CW'(DIV / 2 - 1);

  logic          rx_meta, rx_sync, rx_prev, rx_act;
  logic [CW-1:0] rx_cnt;
  logic [3:0]    rx_idx;
  logic [7:0]    rx_sh;

  // rx_idx: 0 = start-bit confirmation, 1..8 = data bits, 9 = stop bit
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta  <= 1'b1;
      rx_sync  <= 1'b1;
      rx_prev  <= 1'b1;
      rx_act   <= 1'b0;
      rx_cnt   <= '0;
      rx_idx   <= '0;
      rx_sh    <= '0;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      rx_meta  <= rx;
      rx_sync  <= rx_meta;
      rx_prev  <= rx_sync;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
      if (!rx_act) begin
        if (rx_prev && !rx_sync) begin
          rx_act <= 1'b1;
          rx_cnt <= '0;
          rx_idx <= '0;
        end
      end else if (rx_idx == 4'd0) begin
        if (rx_cnt == HALF) begin
          rx_cnt <= '0;
          if (rx_sync) rx_act <= 1'b0;
          else         rx_idx <= 4'd1;
        end else begin
          rx_cnt <= rx_cnt + 1'b1;
        end
      end else if (rx_cnt != BIT_END) begin
        rx_cnt <= rx_cnt + 1'b1;
      end else begin
        rx_cnt <= '0;
        if (rx_idx == 4'd9) begin
          rx_act   <= 1'b0;
          rx_valid <= rx_sync;
          rx_ferr  <= !rx_sync;
        end else begin
          rx_sh  <= {rx_sync, rx_sh[7:1]};
          rx_idx <= rx_idx + 1'b1;
        end
      end
    end
  end

  assign rx_data = rx_sh;

  logic          tx_act;
  logic [CW-1:0] tx_cnt;
  logic [3:0]    tx_idx;
  logic [7:0]    tx_byte;

  // Ready in the last cycle of the stop bit so the next start bit follows with no gap
  assign tx_ready = !tx_act || (tx_idx == 4'd9 && tx_cnt == BIT_END);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx      <= 1'b1;
      tx_act  <= 1'b0;
      tx_cnt  <= '0;
      tx_idx  <= '0;
      tx_byte <= '0;
    end else if (tx_valid && tx_ready) begin
      tx      <= 1'b0;
      tx_act  <= 1'b1;
      tx_cnt  <= '0;
      tx_idx  <= '0;
      tx_byte <= tx_data;
    end else if (tx_act) begin
      if (tx_cnt != BIT_END) begin
        tx_cnt <= tx_cnt + 1'b1;
      end else begin
        tx_cnt <= '0;
        if (tx_idx == 4'd9) begin
          tx_act <= 1'b0;
        end else begin
          tx_idx <= tx_idx + 1'b1;
          tx     <= (tx_idx == 4'd8) ? 1'b1 : tx_byte[tx_idx[2:0]];
        end
      end
    end
  end

endmodule

// File: rtl/uart_wb_master.sv
// UART command FSM driving single classic Wishbone transfers.
// Define UART_WB_MASTER_TIMEOUT_EN to abort bus cycles after TIMEOUT_CYCLES with no termination.
module uart_wb_master
  import uart_wbm_pkg::*;
#(
  parameter int CLK_FREQ       = 10_000_000,
  parameter int BAUD_RATE      = 115200,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_rx,
  output logic        o_tx,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_we,
  output logic [31:0] o_wb_adr,
  output logic [31:0] o_wb_dat,
  output logic [3:0]  o_wb_sel,
  input  logic        i_wb_ack,
  input  logic        i_wb_err,
  input  logic [31:0] i_wb_dat,
  output logic        o_busy
);

  localparam int DIV = CLK_FREQ / BAUD_RATE;

  state_t      state, state_nxt;
  logic        rx_valid, rx_ferr, tx_valid, tx_ready;
  logic [7:0]  rx_data, tx_data;
  logic [1:0]  byte_cnt;
  wb_req_t     cmd;
  logic [31:0] rdata, adr_sh, dat_sh;
  logic        rsp_err, rsp_sent, rsp_last;
  logic        bus_done, bus_err, tmo_hit;

  uart_wbm_serdes #(.DIV(DIV)) u_serdes (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .rx       (i_rx),
    .tx       (o_tx),
    .rx_valid (rx_valid),
    .rx_ferr  (rx_ferr),
    .rx_data  (rx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_data  (tx_data)
  );

`ifdef UART_WB_MASTER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] tmo_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || state != ST_BUS) tmo_cnt <= '0;
    else                             tmo_cnt <= tmo_cnt + 1'b1;
  end

  assign tmo_hit = (tmo_cnt == TMO_LAST);
`else
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT_CYCLES != 0);
  assign tmo_hit    = 1'b0;
`endif

  assign adr_sh = {cmd.adr[23:0], rx_data};
  assign dat_sh = {cmd.dat[23:0], rx_data};
  assign o_busy = (state != ST_IDLE);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    tx_valid  = 1'b0;
    bus_done  = 1'b0;
    bus_err   = 1'b0;
    rsp_last  = (cmd.we || rsp_err) ? 1'b1 : (byte_cnt == 2'd3);
    tx_data   = rsp_err ? RSP_ERR : (cmd.we ? RSP_OK : rdata[31:24]);
    case (state)
      ST_IDLE:
        if (rx_valid && (rx_data == CMD_WRITE || rx_data == CMD_READ)) state_nxt = ST_ADDR;
      ST_ADDR:
        if (rx_ferr) state_nxt = ST_IDLE;
        else if (rx_valid && byte_cnt == 2'd3) state_nxt = cmd.we ? ST_WDATA : ST_BUS;
      ST_WDATA:
        if (rx_ferr) state_nxt = ST_IDLE;
        else if (rx_valid && byte_cnt == 2'd3) state_nxt = ST_BUS;
      ST_BUS: begin
        // an ack landing on the timeout edge still counts as success
        bus_done = i_wb_ack || i_wb_err || tmo_hit;
        bus_err  = i_wb_err || (!i_wb_ack && tmo_hit);
        if (bus_done) state_nxt = ST_RESP;
      end
      ST_RESP: begin
        tx_valid = !rsp_sent;
        if (rsp_sent && tx_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      byte_cnt <= '0;
      cmd      <= '0;
      rdata    <= '0;
      rsp_err  <= 1'b0;
      rsp_sent <= 1'b0;
      o_wb_cyc <= 1'b0;
      o_wb_stb <= 1'b0;
      o_wb_we  <= 1'b0;
      o_wb_adr <= '0;
      o_wb_dat <= '0;
      o_wb_sel <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          byte_cnt <= '0;
          rsp_sent <= 1'b0;
          if (rx_valid) cmd.we <= (rx_data == CMD_WRITE);
        end
        ST_ADDR:
          if (rx_valid) begin
            cmd.adr  <= adr_sh;
            byte_cnt <= byte_cnt + 1'b1;
          end
        ST_WDATA:
          if (rx_valid) begin
            cmd.dat  <= dat_sh;
            byte_cnt <= byte_cnt + 1'b1;
          end
        ST_BUS:
          if (bus_done) begin
            o_wb_cyc <= 1'b0;
            o_wb_stb <= 1'b0;
            rsp_err  <= bus_err;
            rdata    <= i_wb_dat;
          end
        ST_RESP:
          if (tx_valid && tx_ready) begin
            rdata    <= {rdata[23:0], 8'h00};
            byte_cnt <= byte_cnt + 1'b1;
            if (rsp_last) rsp_sent <= 1'b1;
          end
        default: ;
      endcase
      // the final command byte is still in flight, so take it straight from the shifter
      if (state_nxt == ST_BUS && state != ST_BUS) begin
        o_wb_cyc <= 1'b1;
        o_wb_stb <= 1'b1;
        o_wb_we  <= cmd.we;
        o_wb_sel <= 4'hF;
        o_wb_adr <= (state == ST_ADDR)  ? adr_sh : cmd.adr;
        o_wb_dat <= (state == ST_WDATA) ? dat_sh : cmd.dat;
      end
    end
  end

endmodule
